time_set_controller: RTL and testbench

- Downstream consumer of two button stages (MODE, ADJ).
- Holds the running wall-clock time (hours/minutes/seconds) and advances it on a 1 Hz tick.
- Lets the user enter an edit mode, select a field, and increment it by single press or auto-repeat.
- Outputs feed the display/segment driver, including a blank flag for the field being edited.

---
 rtl/clock_pkg.sv | 33 +++
 rtl/wrap_counter.sv | 42 ++++
 rtl/time_set_controller.sv | 154 +++++++++++++++
 tb/tb_time_set_controller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// ----------------------------------------------------------------------------
// clock_pkg
// Shared constants for the wall-clock time-set controller.
//   - State encodings, which are also the values reported on the field output.
//   - Field limits and widths for the minute/second counters and hour width.
//   - next_set_state(): the field order stepped by a short MODE press.
// No ports (package).
// ----------------------------------------------------------------------------
package clock_pkg;

    localparam logic [1:0] STATE_RUN      = 2'd0;
    localparam logic [1:0] STATE_SET_HOUR = 2'd1;
    localparam logic [1:0] STATE_SET_MIN  = 2'd2;
    localparam logic [1:0] STATE_SET_SEC  = 2'd3;

    localparam int unsigned MIN_MODULO = 60;
    localparam int unsigned SEC_MODULO = 60;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;

    // Short MODE press walks hour -> minute -> second -> back to running.
    function automatic logic [1:0] next_set_state(input logic [1:0] state);
        logic [1:0] next;
        case (state)
            STATE_SET_HOUR: next = STATE_SET_MIN;
            STATE_SET_MIN:  next = STATE_SET_SEC;
            default:        next = STATE_RUN;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// ----------------------------------------------------------------------------
// wrap_counter
// Modulo-N up counter with synchronous clear and load-zero.
// Ports:
//   i_clock      system clock
//   i_clear      synchronous clear (wired to the block reset)
//   i_load_zero  functional load of zero (e.g. seconds cleared while editing)
//   i_inc        count up by one, wrapping MODULO-1 -> 0
//   o_value      registered count
//   o_carry      high in the cycle an increment wraps (combinational, feeds
//                the next counter so a full roll-over lands in one cycle)
// ----------------------------------------------------------------------------
module wrap_counter #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned MODULO = 60
) (
    input  logic             i_clock,
    input  logic             i_clear,
    input  logic             i_load_zero,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_value,
    output logic             o_carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] r_value;
    logic             w_at_last;

    assign w_at_last = (r_value == LAST);
    assign o_carry   = i_inc & w_at_last;
    assign o_value   = r_value;

    always_ff @(posedge i_clock) begin
        if (i_clear || i_load_zero) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= w_at_last ? '0 : r_value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// ----------------------------------------------------------------------------
// time_set_controller
// Wall-clock hours/minutes/seconds with a MODE/ADJ button edit mode.
// Ports:
//   i_clock          system clock
//   i_reset          synchronous, active-high reset
//   i_tick           1 Hz pulse, advances time while running
//   i_repeat_tick    auto-repeat / blink pulse
//   i_mode_press     MODE short press: step to the next field (edit only)
//   i_mode_long      MODE long press: enter edit / return to run
//   i_adj_press      ADJ short press: increment field (seconds: clear)
//   i_adj_long       ADJ long press: start auto-repeat (hour/minute)
//   i_adj_debounced  ADJ level, 0 = held, 1 = released
//   o_hours          current hours
//   o_minutes        current minutes
//   o_seconds        current seconds
//   o_field          0 run, 1 hour, 2 minute, 3 second under edit
//   o_blank          display driver blanks the selected field
// ----------------------------------------------------------------------------
module time_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned HOUR_MODULO = 24,
    parameter int unsigned BLINK_DIV   = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_tick,
    input  logic              i_repeat_tick,
    input  logic              i_mode_press,
    input  logic              i_mode_long,
    input  logic              i_adj_press,
    input  logic              i_adj_long,
    input  logic              i_adj_debounced,
    output logic [HOUR_W-1:0] o_hours,
    output logic [MIN_W-1:0]  o_minutes,
    output logic [MIN_W-1:0]  o_seconds,
    output logic [1:0]        o_field,
    output logic              o_blank
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [1:0]         r_state, w_state_d;
    logic               r_repeat, w_repeat_d;
    logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_d;
    logic               r_phase, w_phase_d;
    logic               r_blank, w_blank_d;

    logic w_run, w_in_hm, w_mode_evt, w_adj_inc;
    logic w_sec_inc, w_sec_zero, w_min_inc, w_hour_inc;
    logic w_sec_carry, w_min_carry;
    logic w_hour_carry_unused;  // nothing sits above hours

    assign w_run      = (r_state == STATE_RUN);
    assign w_in_hm    = (r_state == STATE_SET_HOUR) || (r_state == STATE_SET_MIN);
    assign w_mode_evt = i_mode_press | i_mode_long;

    // Press and repeat share one increment; any MODE event masks ADJ.
    assign w_adj_inc = w_in_hm & ~w_mode_evt
                     & (i_adj_press | (r_repeat & ~i_adj_debounced & i_repeat_tick));

    // Carry chain only runs in RUN; in edit each field wraps on its own.
    assign w_sec_inc  = w_run & i_tick;
    assign w_sec_zero = (r_state == STATE_SET_SEC) & i_adj_press & ~w_mode_evt;
    assign w_min_inc  = w_run ? w_sec_carry : ((r_state == STATE_SET_MIN) & w_adj_inc);
    assign w_hour_inc = w_run ? w_min_carry : ((r_state == STATE_SET_HOUR) & w_adj_inc);

    wrap_counter #(.WIDTH(MIN_W), .MODULO(SEC_MODULO)) u_sec (
        .i_clock     (i_clock),
        .i_clear     (i_reset),
        .i_load_zero (w_sec_zero),
        .i_inc       (w_sec_inc),
        .o_value     (o_seconds),
        .o_carry     (w_sec_carry)
    );

    wrap_counter #(.WIDTH(MIN_W), .MODULO(MIN_MODULO)) u_min (
        .i_clock     (i_clock),
        .i_clear     (i_reset),
        .i_load_zero (1'b0),
        .i_inc       (w_min_inc),
        .o_value     (o_minutes),
        .o_carry     (w_min_carry)
    );

    wrap_counter #(.WIDTH(HOUR_W), .MODULO(HOUR_MODULO)) u_hour (
        .i_clock     (i_clock),
        .i_clear     (i_reset),
        .i_load_zero (1'b0),
        .i_inc       (w_hour_inc),
        .o_value     (o_hours),
        .o_carry     (w_hour_carry_unused)
    );

    always_comb begin
        w_state_d = r_state;
        if (i_mode_long) begin
            w_state_d = w_run ? STATE_SET_HOUR : STATE_RUN;
        end else if (i_mode_press && !w_run) begin
            w_state_d = next_set_state(r_state);
        end
    end

    always_comb begin
        w_repeat_d = r_repeat;
        if ((w_state_d != r_state) || !w_in_hm || i_adj_debounced) begin
            w_repeat_d = 1'b0;
        end else if (i_adj_long) begin
            w_repeat_d = 1'b1;
        end
    end

    // Blink restarts from a visible phase on every entry into an edit state.
    always_comb begin
        w_blink_cnt_d = r_blink_cnt;
        w_phase_d     = r_phase;
        if ((w_state_d == STATE_RUN) || (w_state_d != r_state)) begin
            w_blink_cnt_d = '0;
            w_phase_d     = 1'b0;
        end else if (i_repeat_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                w_blink_cnt_d = '0;
                w_phase_d     = ~r_phase;
            end else begin
                w_blink_cnt_d = r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Keep the field visible while it is being auto-repeated.
    assign w_blank_d = (w_state_d != STATE_RUN) & w_phase_d & ~w_repeat_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= STATE_RUN;
            r_repeat    <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
            r_blank     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_repeat    <= w_repeat_d;
            r_blink_cnt <= w_blink_cnt_d;
            r_phase     <= w_phase_d;
            r_blank     <= w_blank_d;
        end
    end

    assign o_field = r_state;
    assign o_blank = r_blank;

endmodule

// File: tb/tb_time_set_controller.sv
// ----------------------------------------------------------------------------
// tb_time_set_controller
// Directed bench for time_set_controller. A 24 h and a 12 h instance share
// all stimulus; outputs are sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_time_set_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, tick = 1'b0, rtick = 1'b0;
    logic mp = 1'b0, ml = 1'b0, ap = 1'b0, al = 1'b0, adb = 1'b1;

    logic [4:0] h, h12;
    logic [5:0] m, s, m12, s12;
    logic [1:0] f, f12;
    logic       b, b12;

    int vectors = 0;
    int errors  = 0;

    time_set_controller #(.HOUR_MODULO(24), .BLINK_DIV(4)) dut (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_repeat_tick(rtick),
        .i_mode_press(mp), .i_mode_long(ml), .i_adj_press(ap), .i_adj_long(al),
        .i_adj_debounced(adb),
        .o_hours(h), .o_minutes(m), .o_seconds(s), .o_field(f), .o_blank(b)
    );

    time_set_controller #(.HOUR_MODULO(12), .BLINK_DIV(4)) dut12 (
        .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_repeat_tick(rtick),
        .i_mode_press(mp), .i_mode_long(ml), .i_adj_press(ap), .i_adj_long(al),
        .i_adj_debounced(adb),
        .o_hours(h12), .o_minutes(m12), .o_seconds(s12), .o_field(f12), .o_blank(b12)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin tick = 1'b1; step(); tick = 1'b0; end
    endtask

    task automatic do_rtick(input int n);
        repeat (n) begin rtick = 1'b1; step(); rtick = 1'b0; end
    endtask

    task automatic do_adj_press(input int n);
        repeat (n) begin ap = 1'b1; step(); ap = 1'b0; end
    endtask

    task automatic do_mode_press();
        mp = 1'b1; step(); mp = 1'b0;
    endtask

    task automatic do_mode_long();
        ml = 1'b1; step(); ml = 1'b0;
    endtask

    task automatic do_adj_long();
        al = 1'b1; step(); al = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        vectors++; if (h !== 5'd0) begin errors++; $display("FAIL reset_hours got=%0d exp=0", h); end
        vectors++; if (m !== 6'd0) begin errors++; $display("FAIL reset_minutes got=%0d exp=0", m); end
        vectors++; if (s !== 6'd0) begin errors++; $display("FAIL reset_seconds got=%0d exp=0", s); end
        vectors++; if (f !== 2'd0) begin errors++; $display("FAIL reset_field got=%0d exp=0", f); end
        vectors++; if (b !== 1'b0) begin errors++; $display("FAIL reset_blank got=%0b exp=0", b); end
        vectors++; if (h12 !== 5'd0) begin errors++; $display("FAIL reset_hours12 got=%0d exp=0", h12); end
    endtask

    task automatic test_run_count();
        apply_reset();
        do_tick(3661);
        vectors++; if (h !== 5'd1) begin errors++; $display("FAIL run_hours got=%0d exp=1", h); end
        vectors++; if (m !== 6'd1) begin errors++; $display("FAIL run_minutes got=%0d exp=1", m); end
        vectors++; if (s !== 6'd1) begin errors++; $display("FAIL run_seconds got=%0d exp=1", s); end
        vectors++; if (f !== 2'd0) begin errors++; $display("FAIL run_field got=%0d exp=0", f); end
        vectors++; if (b !== 1'b0) begin errors++; $display("FAIL run_blank got=%0b exp=0", b); end
        vectors++; if (h12 !== 5'd1) begin errors++; $display("FAIL run_hours12 got=%0d exp=1", h12); end
    endtask

    task automatic test_rollover();
        apply_reset();
        do_tick(59);
        do_mode_long();
        vectors++; if (f !== 2'd1) begin errors++; $display("FAIL roll_enter_field got=%0d exp=1", f); end
        do_adj_press(23);
        do_mode_press();
        do_adj_press(59);
        do_mode_long();
        vectors++; if (f !== 2'd0) begin errors++; $display("FAIL roll_exit_field got=%0d exp=0", f); end
        vectors++; if (h !== 5'd23) begin errors++; $display("FAIL roll_pre_hours got=%0d exp=23", h); end
        vectors++; if (m !== 6'd59) begin errors++; $display("FAIL roll_pre_minutes got=%0d exp=59", m); end
        vectors++; if (s !== 6'd59) begin errors++; $display("FAIL roll_pre_seconds got=%0d exp=59", s); end
        vectors++; if (h12 !== 5'd11) begin errors++; $display("FAIL roll_pre_hours12 got=%0d exp=11", h12); end
        do_tick(1);
        vectors++; if (h !== 5'd0) begin errors++; $display("FAIL roll_hours got=%0d exp=0", h); end
        vectors++; if (m !== 6'd0) begin errors++; $display("FAIL roll_minutes got=%0d exp=0", m); end
        vectors++; if (s !== 6'd0) begin errors++; $display("FAIL roll_seconds got=%0d exp=0", s); end
        vectors++; if (h12 !== 5'd0) begin errors++; $display("FAIL roll_hours12 got=%0d exp=0", h12); end
        vectors++; if (m12 !== 6'd0) begin errors++; $display("FAIL roll_minutes12 got=%0d exp=0", m12); end
        vectors++; if (s12 !== 6'd0) begin errors++; $display("FAIL roll_seconds12 got=%0d exp=0", s12); end
        // Tick and mode_long together: tick lands, then edit starts.
        tick = 1'b1; ml = 1'b1; step(); tick = 1'b0; ml = 1'b0;
        vectors++; if (s !== 6'd1) begin errors++; $display("FAIL tick_ml_seconds got=%0d exp=1", s); end
        vectors++; if (f !== 2'd1) begin errors++; $display("FAIL tick_ml_field got=%0d exp=1", f); end
        vectors++; if (f12 !== 2'd1) begin errors++; $display("FAIL tick_ml_field12 got=%0d exp=1", f12); end
    endtask

    task automatic test_hour_min_edit();
        apply_reset();
        do_mode_long();
        do_adj_press(25);
        vectors++; if (h !== 5'd1) begin errors++; $display("FAIL edit_hours got=%0d exp=1", h); end
        do_mode_press();
        vectors++; if (f !== 2'd2) begin errors++; $display("FAIL edit_field_min got=%0d exp=2", f); end
        do_adj_press(59);
        vectors++; if (m !== 6'd59) begin errors++; $display("FAIL edit_min59 got=%0d exp=59", m); end
        do_adj_press(1);
        vectors++; if (m !== 6'd0) begin errors++; $display("FAIL edit_min_wrap got=%0d exp=0", m); end
        vectors++; if (h !== 5'd1) begin errors++; $display("FAIL edit_no_carry got=%0d exp=1", h); end
        vectors++; if (b !== 1'b0) begin errors++; $display("FAIL edit_blank got=%0b exp=0", b); end
    endtask

    // Continues in SET_MIN from test_hour_min_edit with minutes = 0.
    task automatic test_repeat();
        adb = 1'b0;
        do_adj_long();
        for (int i = 1; i <= 10; i++) begin
            do_rtick(1);
            vectors++;
            if (b !== 1'b0 || m !== 6'(i)) begin
                errors++;
                $display("FAIL repeat_step%0d blank=%0b min=%0d exp blank=0 min=%0d", i, b, m, i);
            end
        end
        adb = 1'b1;
        step();
        do_rtick(4);
        vectors++; if (m !== 6'd10) begin errors++; $display("FAIL repeat_release_min got=%0d exp=10", m); end
        vectors++; if (b !== 1'b1) begin errors++; $display("FAIL repeat_release_blank got=%0b exp=1", b); end
        vectors++; if (h !== 5'd1) begin errors++; $display("FAIL repeat_hours got=%0d exp=1", h); end
    endtask

    task automatic test_sec_clear();
        apply_reset();
        do_tick(37);
        do_mode_long();
        do_mode_press();
        do_mode_press();
        vectors++; if (f !== 2'd3) begin errors++; $display("FAIL sec_field got=%0d exp=3", f); end
        vectors++; if (s !== 6'd37) begin errors++; $display("FAIL sec_pre got=%0d exp=37", s); end
        do_adj_press(1);
        vectors++; if (s !== 6'd0) begin errors++; $display("FAIL sec_clear got=%0d exp=0", s); end
        do_tick(5);
        vectors++; if (s !== 6'd0) begin errors++; $display("FAIL sec_frozen got=%0d exp=0", s); end
        do_mode_press();
        vectors++; if (f !== 2'd0) begin errors++; $display("FAIL sec_to_run got=%0d exp=0", f); end
        do_tick(1);
        vectors++; if (s !== 6'd1) begin errors++; $display("FAIL sec_resume got=%0d exp=1", s); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        do_mode_long();
        mp = 1'b1; ap = 1'b1; step(); mp = 1'b0; ap = 1'b0;
        vectors++; if (f !== 2'd2) begin errors++; $display("FAIL mp_ap_field got=%0d exp=2", f); end
        vectors++; if (h !== 5'd0) begin errors++; $display("FAIL mp_ap_hours got=%0d exp=0", h); end
        ml = 1'b1; ap = 1'b1; step(); ml = 1'b0; ap = 1'b0;
        vectors++; if (f !== 2'd0) begin errors++; $display("FAIL ml_ap_field got=%0d exp=0", f); end
        vectors++; if (m !== 6'd0) begin errors++; $display("FAIL ml_ap_minutes got=%0d exp=0", m); end
        do_mode_long();
        // adj_long while released must not arm repeat.
        adb = 1'b1; al = 1'b1; step(); al = 1'b0;
        adb = 1'b0;
        do_rtick(1);
        vectors++; if (h !== 5'd0) begin errors++; $display("FAIL al_released_hours got=%0d exp=0", h); end
        do_adj_long();
        do_rtick(1);
        ap = 1'b1; rtick = 1'b1; step(); ap = 1'b0; rtick = 1'b0;
        vectors++; if (h !== 5'd2) begin errors++; $display("FAIL ap_rtick_hours got=%0d exp=2", h); end
        adb = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_repeat();
        apply_reset();
        do_mode_long();
        adb = 1'b0;
        do_adj_long();
        do_rtick(3);
        vectors++; if (h !== 5'd3) begin errors++; $display("FAIL midrep_hours got=%0d exp=3", h); end
        rst = 1'b1; rtick = 1'b1; step(); rst = 1'b0; rtick = 1'b0;
        vectors++; if (h !== 5'd0) begin errors++; $display("FAIL midrep_rst_hours got=%0d exp=0", h); end
        vectors++; if (m !== 6'd0) begin errors++; $display("FAIL midrep_rst_minutes got=%0d exp=0", m); end
        vectors++; if (s !== 6'd0) begin errors++; $display("FAIL midrep_rst_seconds got=%0d exp=0", s); end
        vectors++; if (f !== 2'd0) begin errors++; $display("FAIL midrep_rst_field got=%0d exp=0", f); end
        vectors++; if (b !== 1'b0) begin errors++; $display("FAIL midrep_rst_blank got=%0b exp=0", b); end
        // Repeat must not survive reset: re-enter edit, ADJ still held.
        do_mode_long();
        do_rtick(1);
        vectors++; if (h !== 5'd0) begin errors++; $display("FAIL midrep_rearm_hours got=%0d exp=0", h); end
        adb = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_rollover();
        test_hour_min_edit();
        test_repeat();
        test_sec_clear();
        test_same_cycle();
        test_reset_mid_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
